// File: rtl/game_pkg.sv
// Shared types, constants and the seven-segment decode for the attempt counter.
package game_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        RUN = 1'b0,
        WON = 1'b1
    } cnt_state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input bcd_digit_t d);
        logic [6:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0: s = 7'h40;
            4'd1: s = 7'h79;
            4'd2: s = 7'h24;
            4'd3: s = 7'h30;
            4'd4: s = 7'h19;
            4'd5: s = 7'h12;
            4'd6: s = 7'h02;
            4'd7: s = 7'h78;
            4'd8: s = 7'h00;
            4'd9: s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_attempt_counter_if.sv
// Control inputs and display/status outputs of the attempt counter.
interface bcd_attempt_counter_if #(
    parameter int NUM_DIGITS = 2
) ();

    logic                    inc;
    logic                    win;
    logic                    clr;
    logic [4*NUM_DIGITS-1:0] count;
    logic                    overflow;
    logic [7*NUM_DIGITS-1:0] seg;
    logic [4*NUM_DIGITS-1:0] best;
    logic                    best_valid;

    modport master (
        output inc, win, clr,
        input  count, overflow, seg, best, best_valid
    );

    modport slave (
        input  inc, win, clr,
        output count, overflow, seg, best, best_valid
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit register: steps on i_inc, rolls 9 -> 0, flags carry at 9.
module bcd_digit
    import game_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_inc,
    output bcd_digit_t o_q,
    output logic       o_carry
);

    bcd_digit_t r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= '0;
        end else if (i_inc) begin
            r_q <= (r_q >= 4'd9) ? 4'd0 : r_q + 4'd1;
        end
    end

    assign o_q     = r_q;
    assign o_carry = (r_q == 4'd9);

endmodule

// File: rtl/bcd_attempt_counter.sv
// Edge-triggered BCD attempt counter with win freeze/clear and 7-seg output.
// Define BCD_ATTEMPT_BEST_RECORD_EN to keep the lowest count seen at a win.
module bcd_attempt_counter
    import game_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int SATURATE   = 1,
    parameter int WIN_CLEARS = 1
) (
    input logic                clk,
    input logic                reset,
    bcd_attempt_counter_if.slave bus
);

    cnt_state_t r_state;
    logic       r_inc_q;
    logic       r_win_q;
    logic       r_overflow;

    logic       w_inc_edge;
    logic       w_win_edge;
    logic       w_win_evt;
    logic       w_inc_evt;
    logic       w_all9;
    logic       w_step;
    logic       w_dclr;

    bcd_digit_t              w_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_carry;
    logic [NUM_DIGITS-1:0]   w_en;
    logic [4*NUM_DIGITS-1:0] w_count;

    assign w_inc_edge = bus.inc & ~r_inc_q;
    assign w_win_edge = bus.win & ~r_win_q;

    // clr swallows both edges; a win edge swallows a coincident inc edge
    assign w_win_evt = (r_state == RUN) & w_win_edge & ~bus.clr;
    assign w_inc_evt = (r_state == RUN) & w_inc_edge & ~w_win_edge & ~bus.clr;

    assign w_all9 = &w_carry;
    assign w_step = w_inc_evt & ~((SATURATE != 0) & w_all9);
    assign w_dclr = bus.clr | (w_win_evt & (WIN_CLEARS != 0));

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_lsd
            assign w_en[k] = w_step;
        end else begin : g_upper
            assign w_en[k] = w_en[k-1] & w_carry[k-1];
        end

        bcd_digit u_digit (
            .i_clk   (clk),
            .i_rst   (reset),
            .i_clr   (w_dclr),
            .i_inc   (w_en[k]),
            .o_q     (w_q[k]),
            .o_carry (w_carry[k])
        );

        assign w_count[4*k +: 4] = w_q[k];
        assign bus.seg[7*k +: 7] = seg7(w_q[k]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_inc_q    <= 1'b0;
            r_win_q    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_inc_q <= bus.inc;
            r_win_q <= bus.win;
            if (bus.clr) begin
                r_state    <= RUN;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    RUN: begin
                        if (w_win_edge) begin
                            r_state <= WON;
                        end else if (w_inc_edge && w_all9) begin
                            r_overflow <= 1'b1;
                        end
                    end
                    WON: begin
                        if (!bus.win) begin
                            r_state <= RUN;
                        end
                    end
                    default: r_state <= RUN;
                endcase
            end
        end
    end

    assign bus.count    = w_count;
    assign bus.overflow = r_overflow;

`ifdef BCD_ATTEMPT_BEST_RECORD_EN
    logic [4*NUM_DIGITS-1:0] r_best;
    logic                    r_best_valid;

    // Packed valid BCD orders the same as its unsigned binary value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_best       <= {NUM_DIGITS{4'h9}};
            r_best_valid <= 1'b0;
        end else if (w_win_evt) begin
            if (!r_best_valid || (w_count < r_best)) begin
                r_best <= w_count;
            end
            r_best_valid <= 1'b1;
        end
    end

    assign bus.best       = r_best;
    assign bus.best_valid = r_best_valid;
`else
    assign bus.best       = '0;
    assign bus.best_valid = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_attempt_counter.sv
// Scoreboard bench: a saturating/win-clearing DUT and a wrapping/win-freezing DUT.
module tb_bcd_attempt_counter;

    logic clk;
    logic rst;
    logic inc;
    logic win;
    logic clr;

    int n_checks;
    int n_fail;

    bcd_attempt_counter_if #(.NUM_DIGITS(2)) bus_a ();
    bcd_attempt_counter_if #(.NUM_DIGITS(2)) bus_b ();

    assign bus_a.inc = inc;
    assign bus_a.win = win;
    assign bus_a.clr = clr;
    assign bus_b.inc = inc;
    assign bus_b.win = win;
    assign bus_b.clr = clr;

    bcd_attempt_counter #(
        .NUM_DIGITS (2),
        .SATURATE   (1),
        .WIN_CLEARS (1)
    ) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_a)
    );

    bcd_attempt_counter #(
        .NUM_DIGITS (2),
        .SATURATE   (0),
        .WIN_CLEARS (0)
    ) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  c0;
        logic        o0;
        logic [13:0] s0;
        logic [7:0]  b0;
        logic        v0;
        logic [7:0]  c1;
        logic        o1;
        logic [7:0]  b1;
        logic        v1;
    } exp_t;

    exp_t sb[$];

    int m_val [2];
    int m_best [2];
    bit m_ovf [2];
    bit m_won [2];
    bit m_bv [2];
    bit m_iq;
    bit m_wq;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] segx(input int d);
        logic [6:0] t [10];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[d];
    endfunction

    task automatic cyc(input bit r, input bit i, input bit w, input bit c);
        exp_t e;
        exp_t g;
        bit ie;
        bit we;
        rst = r;
        inc = i;
        win = w;
        clr = c;
        ie = i && !m_iq;
        we = w && !m_wq;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_val[k]  = 0;
                m_ovf[k]  = 0;
                m_won[k]  = 0;
                m_best[k] = 99;
                m_bv[k]   = 0;
            end else if (c) begin
                m_val[k] = 0;
                m_ovf[k] = 0;
                m_won[k] = 0;
            end else if (m_won[k]) begin
                if (!w) m_won[k] = 0;
            end else if (we) begin
                if (!m_bv[k] || m_val[k] < m_best[k]) m_best[k] = m_val[k];
                m_bv[k] = 1;
                if (k == 0) m_val[k] = 0;
                m_won[k] = 1;
            end else if (ie) begin
                if (m_val[k] == 99) begin
                    m_ovf[k] = 1;
                    m_val[k] = (k == 0) ? 99 : 0;
                end else begin
                    m_val[k] = m_val[k] + 1;
                end
            end
        end
        m_iq = r ? 1'b0 : i;
        m_wq = r ? 1'b0 : w;
        e.c0 = bcd(m_val[0]);
        e.o0 = m_ovf[0];
        e.s0 = {segx(m_val[0] / 10), segx(m_val[0] % 10)};
        e.c1 = bcd(m_val[1]);
        e.o1 = m_ovf[1];
`ifdef BCD_ATTEMPT_BEST_RECORD_EN
        e.b0 = bcd(m_best[0]);
        e.v0 = m_bv[0];
        e.b1 = bcd(m_best[1]);
        e.v1 = m_bv[1];
`else
        e.b0 = '0;
        e.v0 = 1'b0;
        e.b1 = '0;
        e.v1 = 1'b0;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("cnt_a", 32'(bus_a.count), 32'(g.c0));
        chk("ovf_a", 32'(bus_a.overflow), 32'(g.o0));
        chk("seg_a", 32'(bus_a.seg), 32'(g.s0));
        chk("best_a", 32'(bus_a.best), 32'(g.b0));
        chk("bval_a", 32'(bus_a.best_valid), 32'(g.v0));
        chk("cnt_b", 32'(bus_b.count), 32'(g.c1));
        chk("ovf_b", 32'(bus_b.overflow), 32'(g.o1));
        chk("best_b", 32'(bus_b.best), 32'(g.b1));
        chk("bval_b", 32'(bus_b.best_valid), 32'(g.v1));
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_win();
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        inc = 1'b0;
        win = 1'b0;
        clr = 1'b0;

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_cnt", 32'(bus_a.count), 32'h00);
        chk("rst_seg", 32'(bus_a.seg), 32'h2040);

        pulse(10);
        chk("ten_cnt", 32'(bus_a.count), 32'h10);
        chk("ten_seg0", 32'(bus_a.seg[6:0]), 32'h40);
        chk("ten_seg1", 32'(bus_a.seg[13:7]), 32'h79);

        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("held_cnt", 32'(bus_a.count), 32'h01);

        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(99);
        chk("n99_a", 32'(bus_a.count), 32'h99);
        chk("n99_ovf", 32'(bus_a.overflow), 32'h0);
        pulse(1);
        chk("sat_cnt", 32'(bus_a.count), 32'h99);
        chk("sat_ovf", 32'(bus_a.overflow), 32'h1);
        chk("wrap_cnt", 32'(bus_b.count), 32'h00);
        chk("wrap_ovf", 32'(bus_b.overflow), 32'h1);
        pulse(2);
        chk("sat_hold", 32'(bus_a.count), 32'h99);
        chk("wrap_next", 32'(bus_b.count), 32'h02);

        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(7);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("win_clr", 32'(bus_a.count), 32'h00);
        chk("win_frz", 32'(bus_b.count), 32'h07);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("won_ign", 32'(bus_a.count), 32'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef BCD_ATTEMPT_BEST_RECORD_EN
        chk("best_07", 32'(bus_a.best), 32'h07);
        chk("bval_07", 32'(bus_a.best_valid), 32'h1);
`endif
        pulse(1);
        chk("run_again", 32'(bus_a.count), 32'h01);

        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(12);
        do_win();
        pulse(5);
        do_win();
        pulse(30);
        do_win();
`ifdef BCD_ATTEMPT_BEST_RECORD_EN
        chk("best_05", 32'(bus_a.best), 32'h05);
`endif
        pulse(3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_cnt", 32'(bus_a.count), 32'h00);
        chk("clr_ovf", 32'(bus_a.overflow), 32'h0);
`ifdef BCD_ATTEMPT_BEST_RECORD_EN
        chk("clr_best", 32'(bus_a.best), 32'h05);
`endif

        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("clr_edge", 32'(bus_a.count), 32'h00);

        pulse(9);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        pulse(4);
        chk("post_rst", 32'(bus_b.count), 32'h04);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
